// File: rtl/tdm_demux.sv
// Time-division demultiplexer: splits an interleaved, frame-synced sample stream
// into per-channel holding registers with one-cycle write strobes.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int CW = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                           state, state_nxt;
  logic   [CW-1:0]                  ch_cnt, cnt_nxt;
  logic                             wr_en, err_set, done_set;
  logic   [CW-1:0]                  wr_idx;
  logic   [CHANNELS-1:0]            wr_onehot;
  logic   [CHANNELS-1:0][WIDTH-1:0] regs;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      ch_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ch_cnt <= cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = ch_cnt;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            state_nxt = LOCKED;
            cnt_nxt   = ONE;
          end
        end
        LOCKED: begin
          if (frame_sync)          cnt_nxt   = ONE;
          else if (ch_cnt == '0)   state_nxt = HUNT;
          else if (ch_cnt == LAST) cnt_nxt   = '0;
          else                     cnt_nxt   = ch_cnt + ONE;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Decode of what this cycle's sample does; registered below.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = '0;
    err_set  = 1'b0;
    done_set = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: wr_en = frame_sync;
        LOCKED: begin
          if (frame_sync) begin
            wr_en   = 1'b1;
            err_set = (ch_cnt != '0);
          end else if (ch_cnt == '0) begin
            err_set = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = ch_cnt;
            done_set = (ch_cnt == LAST);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_onehot = '0;
    if (wr_en) wr_onehot[wr_idx] = 1'b1;
  end

  // NOTE: the holding registers are reset because dout must read zero out of
  // reset; a storage array without that need would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= wr_onehot;
      frame_done <= done_set;
      sync_err   <= err_set;
    end
  end

  assign dout   = regs;
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: directed scenarios followed by random traffic,
// checked against a frame-level reference model.
module tb_tdm_demux;
  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_sync = 1'b0;
  logic [C*W-1:0] dout;
  logic [C-1:0]   ch_valid;
  logic           frame_done, locked, sync_err;

  tdm_demux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout), .ch_valid(ch_valid),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0]   cv;
    bit             done;
    bit             err;
    bit             lk;
    logic [C*W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: frame-level view of the link.
  bit       m_locked = 0;
  int       m_next   = 0;
  int       m_regs[C];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [C*W-1:0] model_dout();
    logic [C*W-1:0] v = '0;
    for (int i = 0; i < C; i++) v[i*W +: W] = m_regs[i][W-1:0];
    return v;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_next   = 0;
    for (int i = 0; i < C; i++) m_regs[i] = 0;
  endtask

  task automatic model(input bit v, input bit s, input logic [W-1:0] d);
    int   wr = -1;
    bit   err = 0, done = 0;
    exp_t e;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin wr = 0; m_locked = 1; m_next = 1; end
    end else if (s) begin
      err = (m_next != 0); wr = 0; m_next = 1;
    end else if (m_next == 0) begin
      err = 1; m_locked = 0;
    end else begin
      wr = m_next; done = (m_next == C - 1); m_next = (m_next + 1) % C;
    end
    if (wr >= 0) m_regs[wr] = int'(d);
    if (wr >= 0 || err) begin
      e.cv   = (wr >= 0) ? C'(1) << wr : '0;
      e.done = done;
      e.err  = err;
      e.lk   = m_locked;
      e.data = model_dout();
      exp_q.push_back(e);
    end
  endtask

  // Drive one cycle of input; the sample is accepted at the following edge.
  task automatic send(input bit v, input bit s, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    model(v, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 0, '0);
  endtask

  // Monitor: pops an expected record whenever the DUT presents an event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (ch_valid != '0 || sync_err || frame_done)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got cv=%b err=%b done=%b expected none at %0t",
                   ch_valid, sync_err, frame_done, $time);
        end else begin
          e = exp_q.pop_front();
          check("ch_valid",   64'(ch_valid),   64'(e.cv));
          check("frame_done", 64'(frame_done), 64'(e.done));
          check("sync_err",   64'(sync_err),   64'(e.err));
          check("locked",     64'(locked),     64'(e.lk));
          check("dout",       64'(dout),       64'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    check("reset_dout",   64'(dout),     64'h0);
    check("reset_cv",     64'(ch_valid), 64'h0);
    check("reset_locked", 64'(locked),   64'h0);
    check("reset_err",    64'(sync_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hunt: unsynced samples are dropped
    send(1, 0, 8'h11);
    send(1, 0, 8'h22);
    idle(2);
    @(negedge clk);
    check("hunt_dout",   64'(dout),   64'h0);
    check("hunt_locked", 64'(locked), 64'h0);

    // Normal back-to-back frame
    send(1, 1, 8'hA0); send(1, 0, 8'hA1); send(1, 0, 8'hA2); send(1, 0, 8'hA3);
    idle(2);
    @(negedge clk);
    check("normal_dout", 64'(dout), 64'hA3A2A1A0);

    // Gapped frame
    send(1, 1, 8'hA0); idle(3);
    send(1, 0, 8'hA1); idle(3);
    send(1, 0, 8'hA2); idle(3);
    send(1, 0, 8'hA3); idle(3);

    // Early sync
    send(1, 1, 8'hB0); send(1, 0, 8'hB1); send(1, 1, 8'hC0);
    idle(2);
    @(negedge clk);
    check("early_dout", 64'(dout), 64'hA3A2B1C0);

    // Complete the frame, then missing sync, then relock
    send(1, 0, 8'hC1); send(1, 0, 8'hC2); send(1, 0, 8'hC3);
    send(1, 0, 8'hD0);
    idle(1);
    send(1, 1, 8'hE0);
    idle(2);
    @(negedge clk);
    check("relock_dout",   64'(dout),   64'hC3C2C1E0);
    check("relock_locked", 64'(locked), 64'h1);

    // Asynchronous reset between edges, after channel 1
    send(1, 1, 8'hF0); send(1, 0, 8'hF1); send(0, 0, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_dout",   64'(dout),     64'h0);
    check("async_cv",     64'(ch_valid), 64'h0);
    check("async_locked", 64'(locked),   64'h0);
    check("async_q_empty", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 0, 8'h55);
    idle(2);
    @(negedge clk);
    check("post_reset_dout",   64'(dout),   64'h0);
    check("post_reset_locked", 64'(locked), 64'h0);

    // Random traffic: mostly well-formed frames with occasional framing faults
    for (int i = 0; i < 3000; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_next == 0) s = ($urandom_range(0, 9) != 0);
      else             s = ($urandom_range(0, 19) == 0);
      send(v, s, W'($urandom));
    end
    idle(3);
    @(negedge clk);
    check("final_dout",    64'(dout),   64'(model_dout()));
    check("final_locked",  64'(locked), 64'(m_locked));
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
